// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   Synchronises a raw asynchronous level (switch or pin) into the clk domain
//   and debounces it. A new level is accepted only after it has been seen on
//   the synchronised input for DB_CYCLES consecutive clocks.
//
// Parameters
//   SYNC_STAGES : synchroniser depth on din (2..4)
//   DB_CYCLES   : consecutive stable clocks needed to accept a level
//                 (1 .. 2**CNT_W-1)
//   CNT_W       : stability counter width
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   din   : raw asynchronous input level
//   dout  : debounced, synchronised level
//   busy  : high while a candidate level change is being qualified
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_LO,
    PEND_HI,
    ST_HI,
    PEND_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // With a one-cycle threshold the pending states are never entered.
  localparam bit SINGLE_CYCLE = (DB_CYCLES == 1);

  // Elaboration-time parameter checks.
  if (DB_CYCLES >= (1 << CNT_W)) begin : g_chk_cnt_w
    $error("debounce_sync: DB_CYCLES must be below 2**CNT_W");
  end
  if (DB_CYCLES == 0) begin : g_chk_db_zero
    $error("debounce_sync: DB_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_sync: SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser chain: din enters at bit 0, s is taken from the last flop.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the synchroniser flops are reset (not left free-running) because
      // their reset value is the level the FSM sees right after release.
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM. dout/busy are registered alongside the state so they are a
  // pure function of flop outputs with no path from din.
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LO: begin
          if (s) begin
            if (SINGLE_CYCLE) begin
              state_q <= ST_HI;
              cnt_q   <= '0;
              dout_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // The edge that first sees the new level counts as cycle one.
              state_q <= PEND_HI;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end

        PEND_HI: begin
          if (!s) begin
            // Bounce back to the accepted level: abandon, no dout toggle.
            state_q <= ST_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_HI: begin
          if (!s) begin
            if (SINGLE_CYCLE) begin
              state_q <= ST_LO;
              cnt_q   <= '0;
              dout_q  <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= PEND_LO;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end

        PEND_LO: begin
          if (s) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= ST_LO;
          cnt_q   <= '0;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//   Self-checking bench for debounce_sync. u_dut uses the default parameters;
//   u_dut_fast uses DB_CYCLES=1, SYNC_STAGES=3. Edge numbering inside each
//   scenario: e=1 is the first rising edge that samples the scenario's din.
//   Expected {dout,busy} values are pushed to a queue as stimulus is driven
//   and popped/compared just after the corresponding edge.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic din2;
  logic dout;
  logic busy;
  logic dout2;
  logic busy2;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];   // {dout, busy} expectations for u_dut
  logic       exp2_q[$];  // dout expectations for u_dut_fast

  always #5 clk = ~clk;

  debounce_sync u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .busy (busy)
  );

  debounce_sync #(
    .SYNC_STAGES(3),
    .DB_CYCLES  (1),
    .CNT_W      (4)
  ) u_dut_fast (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din2),
    .dout (dout2),
    .busy (busy2)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with din=1 held, then release and qualify the rise.
  task automatic test_reset();
    logic [1:0] exp;
    logic [1:0] got;
    rst_n = 1'b0;
    din   = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      exp_q.push_back(2'b00);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_hold e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      exp = (e <= 2) ? 2'b00 : (e <= 9) ? 2'b01 : 2'b10;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // From dout=1, din falls and stays low.
  task automatic test_fall();
    logic [1:0] exp;
    logic [1:0] got;
    for (int e = 1; e <= 12; e++) begin
      din = 1'b0;
      exp = (e <= 2) ? 2'b10 : (e <= 9) ? 2'b11 : 2'b00;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fall e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // din high for 3 sampled clocks from dout=0: busy for 3 cycles, no toggle.
  task automatic test_glitch();
    logic [1:0] exp;
    logic [1:0] got;
    for (int e = 1; e <= 10; e++) begin
      din = (e <= 3);
      exp = (e >= 3 && e <= 5) ? 2'b01 : 2'b00;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // High pulse of 7 clocks is rejected; 8 clocks is accepted and later falls.
  task automatic test_threshold();
    logic [1:0] exp;
    logic [1:0] got;
    for (int e = 1; e <= 12; e++) begin
      din = (e <= 7);
      exp = (e >= 3 && e <= 9) ? 2'b01 : 2'b00;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL thresh7 e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
    for (int e = 1; e <= 20; e++) begin
      din = (e <= 8);
      if (e <= 2)       exp = 2'b00;
      else if (e <= 9)  exp = 2'b01;
      else if (e == 10) exp = 2'b10;
      else if (e <= 17) exp = 2'b11;
      else              exp = 2'b00;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL thresh8 e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // Rise to dout=1, then a falling edge with a one-clock high bounce at e=6.
  task automatic test_bounce();
    logic [1:0] exp;
    logic [1:0] got;
    for (int e = 1; e <= 12; e++) begin
      din = 1'b1;
      exp = (e <= 2) ? 2'b00 : (e <= 9) ? 2'b01 : 2'b10;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce_rise e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
    for (int e = 1; e <= 18; e++) begin
      din = (e == 6);
      if (e <= 2)       exp = 2'b10;
      else if (e <= 7)  exp = 2'b11;
      else if (e == 8)  exp = 2'b10;
      else if (e <= 15) exp = 2'b11;
      else              exp = 2'b00;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce_fall e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // Reset while a rise is pending, then re-qualify from scratch.
  task automatic test_reset_mid();
    logic [1:0] exp;
    logic [1:0] got;
    for (int e = 1; e <= 5; e++) begin
      din = 1'b1;
      exp = (e <= 2) ? 2'b00 : 2'b01;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_pend e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
    rst_n = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      exp_q.push_back(2'b00);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset e%0d: dout,busy=%b expected %b", e, got, exp);
      end
      if (e == 1) begin
        checks++;
        if (u_dut.cnt_q !== 4'd0) begin
          errors++;
          $display("FAIL mid_reset_cnt: cnt=%0d expected 0", u_dut.cnt_q);
        end
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      exp = (e <= 2) ? 2'b00 : (e <= 9) ? 2'b01 : 2'b10;
      exp_q.push_back(exp);
      tick();
      got = {dout, busy};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_requal e%0d: dout,busy=%b expected %b", e, got, exp);
      end
    end
  endtask

  // DB_CYCLES=1, SYNC_STAGES=3: dout follows din three edges late, busy stays 0.
  // The queue is primed with the three reset-state synchroniser values.
  task automatic test_fast();
    logic exp;
    for (int i = 0; i < 3; i++) exp2_q.push_back(1'b0);
    for (int e = 1; e <= 40; e++) begin
      din2 = 1'($urandom_range(1, 0));
      exp2_q.push_back(din2);
      tick();
      exp = exp2_q.pop_front();
      checks++;
      if (dout2 !== exp) begin
        errors++;
        $display("FAIL fast_dout e%0d: dout=%b expected %b", e, dout2, exp);
      end
      checks++;
      if (busy2 !== 1'b0) begin
        errors++;
        $display("FAIL fast_busy e%0d: busy=%b expected 0", e, busy2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    din2  = 1'b0;
    test_reset();
    test_fall();
    test_glitch();
    test_threshold();
    test_bounce();
    test_reset_mid();
    din = 1'b0;
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
